// File: rtl/banked_dual_read_memory.sv
// banked_dual_read_memory: one byte-masked write port, two registered read ports,
// write-first forwarding and a zeroing sweep after every reset.
module banked_dual_read_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_write_enable,
  input  logic [DATA_WIDTH/8-1:0] write_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [ADDR_WIDTH-1:0]   read_address1,
  input  logic [ADDR_WIDTH-1:0]   read_address2,
  output logic [DATA_WIDTH-1:0]   read_data1,
  output logic [DATA_WIDTH-1:0]   read_data2,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0]   rd2_q, rd2_d;

  logic                    wa_ok, ra1_ok, ra2_ok;
  logic [DATA_WIDTH-1:0]   old_word, merged;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  always_comb begin
    wa_ok  = {1'b0, write_address} < DEPTH_W;
    ra1_ok = {1'b0, read_address1} < DEPTH_W;
    ra2_ok = {1'b0, read_address2} < DEPTH_W;
    old_word = wa_ok ? mem_q[write_address] : '0;
    merged   = old_word;
    for (int b = 0; b < NB; b++) begin
      if (write_byte_enable[b]) begin
        merged[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

  // Reads see the merged word when they hit this edge's write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = write_address;
    wr_data = merged;
    rd1_d   = '0;
    rd2_d   = '0;
    unique case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        wr_en = mem_write_enable && wa_ok;
        if (ra1_ok) begin
          rd1_d = (wr_en && read_address1 == write_address)
                  ? merged : mem_q[read_address1];
        end
        if (ra2_ok) begin
          rd2_d = (wr_en && read_address2 == write_address)
                  ? merged : mem_q[read_address2];
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;
  assign busy       = (state_q == CLEAR);

endmodule
